// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: front-end flow controller driving next-PC, PCWrite and IF/ID, ID/EX controls
//   Sequences traps, EX-resolved redirects, instruction-memory wait stalls and load-use
//   interlocks. The PC register loads o_npc every clock, so a hold drives o_npc = i_pc.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   i_pc                    current PC
//   i_id_rs, i_id_rt        ID-stage source registers; i_id_uses_rt qualifies rt
//   i_ex_memread, i_ex_rd   EX-stage load flag and destination register
//   i_ex_redirect           EX resolved taken branch/jump to i_ex_target
//   i_imem_ready            instruction fetch valid this cycle
//   i_trap_req              level trap request
//   o_npc, o_pc_write       next PC and PCWrite
//   o_ifid_write            IF/ID load enable
//   o_ifid_flush            IF/ID bubble insert
//   o_idex_flush            ID/EX bubble insert
//   o_stall_cycles          saturating count of cycles with o_pc_write = 0
//   o_flush_events          saturating count of accepted traps and redirects
module pc_flow_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_pc,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_redirect,
    input  logic [31:0]      i_ex_target,
    input  logic             i_imem_ready,
    input  logic             i_trap_req,
    output logic [31:0]      o_npc,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_events
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP_DRAIN} state_t;
    state_t           r_state, w_next;
    logic             w_lu_hazard;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
    assign w_lu_hazard = i_ex_memread && (i_ex_rd != 5'd0) &&
                         ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
    // RUN and MEM_WAIT share the same priority chain; only TRAP_DRAIN differs.
    always_comb begin
        o_npc        = i_pc + 32'd4;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        w_flush_evt  = 1'b0;
        w_next       = RUN;
        if (!rst_n) begin
            o_npc        = RESET_PC;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (r_state == TRAP_DRAIN) begin
            o_npc        = i_pc;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (i_trap_req || i_ex_redirect) begin
            o_npc        = i_trap_req ? TRAP_VEC : i_ex_target;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            w_flush_evt  = 1'b1;
            w_next       = i_trap_req ? TRAP_DRAIN : RUN;
        end else if (!i_imem_ready) begin
            o_npc        = i_pc;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            w_next       = MEM_WAIT;
        end else if (w_lu_hazard) begin
            o_npc        = i_pc;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state <= w_next;
            if (!o_pc_write && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_flush_evt && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// tb_pc_flow_ctrl: directed and randomized checks of pc_flow_ctrl against spec values and a reference model
module tb_pc_flow_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rt = 1'b0, ex_memread = 1'b0, ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        imem_ready = 1'b1, trap_req = 1'b0;
    logic [31:0] npc;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic [3:0]  stall_cycles, flush_events;
    int          total = 0, bad = 0;

    pc_flow_ctrl #(.RESET_PC(32'h0), .TRAP_VEC(32'h80), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_pc(pc), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
        .i_ex_redirect(ex_redirect), .i_ex_target(ex_target), .i_imem_ready(imem_ready),
        .i_trap_req(trap_req), .o_npc(npc), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
        .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rd = 0;
        ex_redirect = 0; ex_target = 0; imem_ready = 1; trap_req = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 0; idle();
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 0; pc = 32'h1234; #1;
        total++; if (npc !== 32'h0) begin bad++; $display("FAIL reset_npc got=%h exp=0", npc); end
        total++; if ({pc_write, ifid_write, ifid_flush, idex_flush} !== 4'b0011) begin bad++; $display("FAIL reset_ctl got=%b exp=0011", {pc_write, ifid_write, ifid_flush, idex_flush}); end
        total++; if ({stall_cycles, flush_events} !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", {stall_cycles, flush_events}); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_load_use();
        apply_reset();
        pc = 32'h40; ex_memread = 1; ex_rd = 5; id_rs = 5; #1;
        total++; if ({npc, pc_write, ifid_write, ifid_flush, idex_flush} !== {32'h40, 4'b0001}) begin bad++; $display("FAIL lu_stall got=%h/%b exp=40/0001", npc, {pc_write, ifid_write, ifid_flush, idex_flush}); end
        @(negedge clk); ex_memread = 0; #1;
        total++; if ({npc, pc_write} !== {32'h44, 1'b1}) begin bad++; $display("FAIL lu_release got=%h/%b exp=44/1", npc, pc_write); end
        total++; if (stall_cycles !== 4'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
        @(negedge clk); pc = 32'h10; ex_memread = 1; ex_rd = 0; id_rs = 0; #1;
        total++; if ({npc, pc_write} !== {32'h14, 1'b1}) begin bad++; $display("FAIL lu_rd0 got=%h/%b exp=14/1", npc, pc_write); end
        @(negedge clk); ex_rd = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1; #1;
        total++; if ({npc, pc_write, idex_flush} !== {32'h10, 2'b01}) begin bad++; $display("FAIL lu_rt got=%h/%b exp=10/01", npc, {pc_write, idex_flush}); end
        @(negedge clk); id_uses_rt = 0; #1;
        total++; if ({npc, pc_write} !== {32'h14, 1'b1}) begin bad++; $display("FAIL lu_rt_unused got=%h/%b exp=14/1", npc, pc_write); end
        idle();
    endtask

    task automatic test_redirect();
        apply_reset();
        pc = 32'h50; ex_redirect = 1; ex_target = 32'h200; #1;
        total++; if ({npc, pc_write, ifid_flush, idex_flush} !== {32'h200, 3'b111}) begin bad++; $display("FAIL redir got=%h/%b exp=200/111", npc, {pc_write, ifid_flush, idex_flush}); end
        @(negedge clk); ex_redirect = 0; pc = 32'h200; #1;
        total++; if ({npc, flush_events} !== {32'h204, 4'd1}) begin bad++; $display("FAIL redir_after got=%h/%0d exp=204/1", npc, flush_events); end
        idle();
    endtask

    task automatic test_trap_race();
        apply_reset();
        pc = 32'h60; trap_req = 1; ex_redirect = 1; ex_target = 32'h300; #1;
        total++; if ({npc, pc_write, ifid_flush, idex_flush} !== {32'h80, 3'b111}) begin bad++; $display("FAIL trap_race got=%h/%b exp=80/111", npc, {pc_write, ifid_flush, idex_flush}); end
        @(negedge clk); trap_req = 0; pc = 32'h80; #1;
        total++; if ({npc, pc_write, ifid_write, ifid_flush, idex_flush} !== {32'h80, 4'b0011}) begin bad++; $display("FAIL trap_drain got=%h/%b exp=80/0011", npc, {pc_write, ifid_write, ifid_flush, idex_flush}); end
        @(negedge clk); ex_redirect = 0; #1;
        total++; if ({npc, pc_write, stall_cycles, flush_events} !== {32'h84, 1'b1, 4'd1, 4'd1}) begin bad++; $display("FAIL trap_exit got=%h/%b/%0d/%0d exp=84/1/1/1", npc, pc_write, stall_cycles, flush_events); end
        idle();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        pc = 32'h100; imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++; if ({npc, pc_write, ifid_write, ifid_flush} !== {32'h100, 3'b001}) begin bad++; $display("FAIL mem_wait[%0d] got=%h/%b exp=100/001", i, npc, {pc_write, ifid_write, ifid_flush}); end
        end
        @(negedge clk); imem_ready = 1; #1;
        total++; if ({npc, pc_write, stall_cycles} !== {32'h104, 1'b1, 4'd3}) begin bad++; $display("FAIL mem_done got=%h/%b/%0d exp=104/1/3", npc, pc_write, stall_cycles); end
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        imem_ready = 0;
        repeat (20) @(negedge clk);
        imem_ready = 1; #1;
        total++; if (stall_cycles !== 4'd15) begin bad++; $display("FAIL sat got=%0d exp=15", stall_cycles); end
        @(negedge clk); imem_ready = 0;
        @(negedge clk); pc = 32'h8; rst_n = 0; #1;
        total++; if ({npc, stall_cycles, flush_events} !== {32'h0, 8'h00}) begin bad++; $display("FAIL rst_mid got=%h/%0d/%0d exp=0/0/0", npc, stall_cycles, flush_events); end
        @(negedge clk); rst_n = 1; imem_ready = 1; ex_redirect = 1; ex_target = 32'h40; #1;
        total++; if ({npc, pc_write} !== {32'h40, 1'b1}) begin bad++; $display("FAIL rst_run got=%h/%b exp=40/1", npc, pc_write); end
        idle();
    endtask

    // Reference model: drain flag plus integer counters; outputs follow the priority rules.
    task automatic test_random();
        bit          drain;
        int          m_stall, m_flush;
        logic [31:0] e_npc;
        logic [3:0]  e_ctl;
        bit          haz, evt;
        apply_reset();
        drain = 0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 400; n++) begin
            if (n > 0) @(negedge clk);
            rst_n      = ($urandom_range(0, 39) != 0);
            pc         = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            trap_req   = ($urandom_range(0, 7) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_target  = $urandom;
            imem_ready = ($urandom_range(0, 3) != 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            #1;
            if (!rst_n) begin drain = 0; m_stall = 0; m_flush = 0; end
            haz = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
            evt = 0;
            if (!rst_n)                     begin e_npc = 32'h0;      e_ctl = 4'b0011; end
            else if (drain)                 begin e_npc = pc;         e_ctl = 4'b0011; end
            else if (trap_req)              begin e_npc = 32'h80;     e_ctl = 4'b1111; evt = 1; end
            else if (ex_redirect)           begin e_npc = ex_target;  e_ctl = 4'b1111; evt = 1; end
            else if (!imem_ready)           begin e_npc = pc;         e_ctl = 4'b0010; end
            else if (haz)                   begin e_npc = pc;         e_ctl = 4'b0001; end
            else                            begin e_npc = pc + 4;     e_ctl = 4'b1100; end
            total++; if (npc !== e_npc) begin bad++; $display("FAIL rnd_npc[%0d] got=%h exp=%h", n, npc, e_npc); end
            total++; if ({pc_write, ifid_write, ifid_flush, idex_flush} !== e_ctl) begin bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", n, {pc_write, ifid_write, ifid_flush, idex_flush}, e_ctl); end
            total++; if (stall_cycles !== 4'(m_stall) || flush_events !== 4'(m_flush)) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, stall_cycles, flush_events, m_stall, m_flush); end
            if (rst_n) begin
                if (!e_ctl[3] && m_stall < 15) m_stall++;
                if (evt && m_flush < 15) m_flush++;
                drain = !drain && trap_req;
            end
        end
        @(negedge clk); rst_n = 1; idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_trap_race();
        test_mem_wait();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
